// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-entry registered pipeline stage with skid buffer, flush and async clear
module pipe_stage_reg #(
    parameter int          PC_WIDTH = 32,
    parameter int          IR_WIDTH = 32,
    parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
    input  logic                clk,        // single clock, rising edge
    input  logic                clear,      // asynchronous active-high reset
    input  logic                flush,      // synchronous squash of held entries
    input  logic                in_valid,   // upstream offers pc_in/ir_in
    output logic                in_ready,   // stage can accept this cycle
    input  logic [PC_WIDTH-1:0] pc_in,      // upstream PC
    input  logic [IR_WIDTH-1:0] ir_in,      // upstream instruction
    output logic                out_valid,  // head entry is live
    input  logic                out_ready,  // downstream accepts this cycle
    output logic [PC_WIDTH-1:0] pc_out,     // head-entry PC
    output logic [IR_WIDTH-1:0] ir_out,     // head-entry instruction, bubble when empty
    output logic [1:0]          count       // held entries, 0..2
);

    // Bubble instruction, truncated or zero-extended to the instruction width.
    localparam logic [IR_WIDTH-1:0] BUBBLE_IR = IR_WIDTH'(NOP_INSN);
    localparam logic [PC_WIDTH-1:0] BUBBLE_PC = '0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [PC_WIDTH-1:0]   main_pc_q;
    logic [PC_WIDTH-1:0]   main_pc_d;
    logic [IR_WIDTH-1:0]   main_ir_q;
    logic [IR_WIDTH-1:0]   main_ir_d;
    logic [PC_WIDTH-1:0]   skid_pc_q;
    logic [PC_WIDTH-1:0]   skid_pc_d;
    logic [IR_WIDTH-1:0]   skid_ir_q;
    logic [IR_WIDTH-1:0]   skid_ir_d;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [1:0]            count_q;
    logic [1:0]            count_d;
    logic                  in_fire;
    logic                  out_fire;

    // Handshake flags come from registered ready/valid, so the only
    // combinational use of in_valid/out_ready is in next-state logic.
    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        state_d   = state_q;
        main_pc_d = main_pc_q;
        main_ir_d = main_ir_q;
        skid_pc_d = skid_pc_q;
        skid_ir_d = skid_ir_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_pc_d = pc_in;
                    main_ir_d = ir_in;
                    state_d   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    // Head leaves and the new entry takes its place.
                    main_pc_d = pc_in;
                    main_ir_d = ir_in;
                end else if (in_fire) begin
                    skid_pc_d = pc_in;
                    skid_ir_d = ir_in;
                    state_d   = ST_FULL;
                end else if (out_fire) begin
                    main_pc_d = BUBBLE_PC;
                    main_ir_d = BUBBLE_IR;
                    state_d   = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the head can move.
                if (out_fire) begin
                    main_pc_d = skid_pc_q;
                    main_ir_d = skid_ir_q;
                    skid_pc_d = BUBBLE_PC;
                    skid_ir_d = BUBBLE_IR;
                    state_d   = ST_ONE;
                end
            end
            default: begin
                main_pc_d = BUBBLE_PC;
                main_ir_d = BUBBLE_IR;
                skid_pc_d = BUBBLE_PC;
                skid_ir_d = BUBBLE_IR;
                state_d   = ST_EMPTY;
            end
        endcase

        // Flush wins over everything; an output transfer in the same cycle
        // has already been taken by downstream, the rest is discarded.
        if (flush) begin
            main_pc_d = BUBBLE_PC;
            main_ir_d = BUBBLE_IR;
            skid_pc_d = BUBBLE_PC;
            skid_ir_d = BUBBLE_IR;
            state_d   = ST_EMPTY;
        end
    end

    always_comb begin
        count_d = 2'd0;
        case (state_d)
            ST_EMPTY: count_d = 2'd0;
            ST_ONE:   count_d = 2'd1;
            ST_FULL:  count_d = 2'd2;
            default:  count_d = 2'd0;
        endcase
    end

    // Status outputs are registered copies decoded from the next state so
    // every output pin is a flop.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q     <= ST_EMPTY;
            main_pc_q   <= BUBBLE_PC;
            main_ir_q   <= BUBBLE_IR;
            skid_pc_q   <= BUBBLE_PC;
            skid_ir_q   <= BUBBLE_IR;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_pc_q   <= main_pc_d;
            main_ir_q   <= main_ir_d;
            skid_pc_q   <= skid_pc_d;
            skid_ir_q   <= skid_ir_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
            count_q     <= count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign pc_out    = main_pc_q;
    assign ir_out    = main_ir_q;
    assign count     = count_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

    logic        clk;
    logic        clear;

    logic        flush_a;
    logic        iv_a;
    logic        ird_a;
    logic [31:0] pc_a;
    logic [31:0] ir_a;
    logic        ov_a;
    logic        ordy_a;
    logic [31:0] pco_a;
    logic [31:0] iro_a;
    logic [1:0]  cnt_a;

    logic        flush_b;
    logic        iv_b;
    logic        ird_b;
    logic [15:0] pc_b;
    logic [23:0] ir_b;
    logic        ov_b;
    logic        ordy_b;
    logic [15:0] pco_b;
    logic [23:0] iro_b;
    logic [1:0]  cnt_b;

    int n_cmp;
    int n_bad;

    pipe_stage_reg dut_a (
        .clk(clk), .clear(clear), .flush(flush_a),
        .in_valid(iv_a), .in_ready(ird_a), .pc_in(pc_a), .ir_in(ir_a),
        .out_valid(ov_a), .out_ready(ordy_a), .pc_out(pco_a), .ir_out(iro_a),
        .count(cnt_a)
    );

    pipe_stage_reg #(
        .PC_WIDTH(16), .IR_WIDTH(24), .NOP_INSN(24'h000013)
    ) dut_b (
        .clk(clk), .clear(clear), .flush(flush_b),
        .in_valid(iv_b), .in_ready(ird_b), .pc_in(pc_b), .ir_in(ir_b),
        .out_valid(ov_b), .out_ready(ordy_b), .pc_out(pco_b), .ir_out(iro_b),
        .count(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_a(input string tag, input logic [1:0] c, input logic v, input logic r,
                         input logic [31:0] p, input logic [31:0] i);
        chk({tag, ".count"}, 32'(cnt_a), 32'(c));
        chk({tag, ".out_valid"}, 32'(ov_a), 32'(v));
        chk({tag, ".in_ready"}, 32'(ird_a), 32'(r));
        chk({tag, ".pc_out"}, pco_a, p);
        chk({tag, ".ir_out"}, iro_a, i);
    endtask

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] pc;
        logic [31:0] ir;
        logic        ordy;
        logic [1:0]  cnt;
        logic        ov;
        logic        ird;
        logic [31:0] epc;
        logic [31:0] eir;
    } vec_t;

    vec_t tv[16];

    // Model for dut_b: a plain FIFO of {pc, ir}, capacity two.
    logic [39:0] model_q[$];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clear = 1'b1;
        flush_a = 0; iv_a = 0; pc_a = 0; ir_a = 0; ordy_a = 0;
        flush_b = 0; iv_b = 0; pc_b = 0; ir_b = 0; ordy_b = 0;

        // Pass-through with out_ready high.
        tv[0]  = '{0, 1, 32'h100, 32'h11, 1, 2'd1, 1, 1, 32'h100, 32'h11};
        tv[1]  = '{0, 1, 32'h104, 32'h12, 1, 2'd1, 1, 1, 32'h104, 32'h12};
        tv[2]  = '{0, 1, 32'h108, 32'h13, 1, 2'd1, 1, 1, 32'h108, 32'h13};
        tv[3]  = '{0, 0, 32'h0,   32'h0,  1, 2'd0, 0, 1, 32'h0,   32'h0};
        // Backpressure, stall of third offer, then drain in order.
        tv[4]  = '{0, 1, 32'h10, 32'hAAAA0001, 0, 2'd1, 1, 1, 32'h10, 32'hAAAA0001};
        tv[5]  = '{0, 1, 32'h14, 32'hAAAA0002, 0, 2'd2, 1, 0, 32'h10, 32'hAAAA0001};
        tv[6]  = '{0, 1, 32'h18, 32'hAAAA0003, 0, 2'd2, 1, 0, 32'h10, 32'hAAAA0001};
        tv[7]  = '{0, 1, 32'h18, 32'hAAAA0003, 1, 2'd1, 1, 1, 32'h14, 32'hAAAA0002};
        tv[8]  = '{0, 1, 32'h18, 32'hAAAA0003, 1, 2'd1, 1, 1, 32'h18, 32'hAAAA0003};
        tv[9]  = '{0, 0, 32'h0,  32'h0,        1, 2'd0, 0, 1, 32'h0,  32'h0};
        // Flush while full with a live offer.
        tv[10] = '{0, 1, 32'h20, 32'hB1, 0, 2'd1, 1, 1, 32'h20, 32'hB1};
        tv[11] = '{0, 1, 32'h24, 32'hB2, 0, 2'd2, 1, 0, 32'h20, 32'hB1};
        tv[12] = '{1, 1, 32'h28, 32'hB3, 0, 2'd0, 0, 1, 32'h0,  32'h0};
        // Flush in ONE drops an offer that in_ready would have accepted.
        tv[13] = '{0, 1, 32'h30, 32'hC1, 0, 2'd1, 1, 1, 32'h30, 32'hC1};
        tv[14] = '{1, 1, 32'h34, 32'hC2, 1, 2'd0, 0, 1, 32'h0,  32'h0};
        tv[15] = '{0, 0, 32'h0,  32'h0,  1, 2'd0, 0, 1, 32'h0,  32'h0};

        #2;
        chk_a("reset_async", 2'd0, 1'b0, 1'b1, 32'h0, 32'h0);
        chk("reset_b.ir_out", 32'(iro_b), 32'h13);
        chk("reset_b.count", 32'(cnt_b), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk_a("reset_held", 2'd0, 1'b0, 1'b1, 32'h0, 32'h0);

        for (int k = 0; k < 16; k++) begin
            flush_a = tv[k].fl;
            iv_a    = tv[k].iv;
            pc_a    = tv[k].pc;
            ir_a    = tv[k].ir;
            ordy_a  = tv[k].ordy;
            @(posedge clk); #1;
            chk_a($sformatf("vec%0d", k), tv[k].cnt, tv[k].ov, tv[k].ird, tv[k].epc, tv[k].eir);
        end
        flush_a = 0; iv_a = 0; ordy_a = 0;

        // Async clear mid-cycle while FULL, then a fresh entry after release.
        iv_a = 1; pc_a = 32'h50; ir_a = 32'hD1;
        @(posedge clk); #1;
        pc_a = 32'h54; ir_a = 32'hD2;
        @(posedge clk); #1;
        iv_a = 0;
        chk_a("full_before_clear", 2'd2, 1'b1, 1'b0, 32'h50, 32'hD1);
        #2 clear = 1'b1;
        #1 chk_a("clear_midcycle", 2'd0, 1'b0, 1'b1, 32'h0, 32'h0);
        #1 clear = 1'b0;
        iv_a = 1; pc_a = 32'h200; ir_a = 32'h77;
        @(posedge clk); #1;
        iv_a = 0;
        chk_a("after_clear", 2'd1, 1'b1, 1'b1, 32'h200, 32'h77);
        ordy_a = 1;
        @(posedge clk); #1;
        ordy_a = 0;
        chk_a("after_clear_drain", 2'd0, 1'b0, 1'b1, 32'h0, 32'h0);

        // Randomised traffic on the narrow instance against the FIFO model.
        model_q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic in_go;
            logic out_go;
            iv_b    = ($urandom_range(0, 3) != 0);
            ordy_b  = ($urandom_range(0, 2) != 0);
            flush_b = ($urandom_range(0, 63) == 0);
            pc_b    = 16'(cyc);
            ir_b    = 24'($urandom);
            in_go   = iv_b && (model_q.size() < 2);
            out_go  = ordy_b && (model_q.size() > 0);
            if (out_go) void'(model_q.pop_front());
            if (flush_b) model_q.delete();
            else if (in_go) model_q.push_back({pc_b, ir_b});
            @(posedge clk); #1;
            chk("rnd.count", 32'(cnt_b), 32'(model_q.size()));
            chk("rnd.out_valid", 32'(ov_b), 32'(model_q.size() > 0));
            chk("rnd.in_ready", 32'(ird_b), 32'(model_q.size() < 2));
            if (model_q.size() > 0) begin
                chk("rnd.pc_out", 32'(pco_b), 32'(model_q[0][39:24]));
                chk("rnd.ir_out", 32'(iro_b), 32'(model_q[0][23:0]));
            end else begin
                chk("rnd.pc_out_empty", 32'(pco_b), 32'h0);
                chk("rnd.ir_out_empty", 32'(iro_b), 32'h13);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
